// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the data-memory port. Accepts one load/store at a time
//   (RISC-V funct3 sizes). It drives a byte-addressed, 64-bit wide memory using
//   8-byte aligned accesses. Stores narrower than a doubleword are done as a
//   read-modify-write. The unit returns extended load data or an error flag
//   through a valid/ready response.
//
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_store, req_funct3,        request: direction, size/sign,
//   req_addr, req_wdata           byte address, right-aligned store data
//   resp_valid/resp_ready         response handshake
//   resp_rdata, resp_err          extended load data, error flag
//   MemRead, MemWrite, Mem_Addr,  memory port (Mem_Addr always 8-byte aligned,
//   Write_Data, Read_Data         Read_Data combinational in the same cycle)
//
// Build option
//   LSU_BOUNDS_CHECK_EN  defined: an access with aligned address + 8 > MEM_BYTES
//                        is rejected with resp_err. Undefined: the aligned
//                        address wraps modulo MEM_BYTES.
//
// state | meaning
// IDLE  | ready for a request
// RD    | read the aligned doubleword into buf_q
// WR    | write the doubleword (full store or merged lanes)
// RESP  | hold the response until resp_ready

module load_store_unit #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    input  logic [63:0] Read_Data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [2:0]  off_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] buf_q;
    logic        err_q;

    logic [63:0] req_al;
    logic [63:0] req_mem_addr;
    logic        req_misalign;
    logic        req_illegal;
    logic        req_oob;
    logic        req_err;

    assign req_al = {req_addr[63:3], 3'b000};

    always_comb begin
        req_misalign = 1'b0;
        case (req_funct3[1:0])
            2'd0:    req_misalign = 1'b0;
            2'd1:    req_misalign = req_addr[0];
            2'd2:    req_misalign = |req_addr[1:0];
            default: req_misalign = |req_addr[2:0];
        endcase
    end

    assign req_illegal = req_store ? req_funct3[2] : (req_funct3 == 3'b111);

`ifdef LSU_BOUNDS_CHECK_EN
    // Compared as al > MEM_BYTES-8 so that very large addresses cannot wrap the sum.
    assign req_oob      = req_al > 64'(MEM_BYTES - 8);
    assign req_mem_addr = req_al;
`else
    assign req_oob      = 1'b0;
    assign req_mem_addr = req_al & 64'(MEM_BYTES - 1);
`endif

    assign req_err = req_misalign | req_illegal | req_oob;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_d = RESP;
                    else if (req_store && (req_funct3[1:0] == 2'd3))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = store_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            off_q    <= 3'd0;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            buf_q    <= 64'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                off_q    <= req_addr[2:0];
                addr_q   <= req_mem_addr;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
            if (state_q == RD)
                buf_q <= Read_Data;
        end
    end

    logic [63:0] size_mask;
    logic [5:0]  shamt;
    logic [63:0] merged;
    logic [63:0] shifted;
    logic [63:0] load_data;
    logic        sgn;

    always_comb begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (funct3_q[1:0])
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign shamt   = {off_q, 3'b000};
    assign merged  = (buf_q & ~(size_mask << shamt)) | ((wdata_q & size_mask) << shamt);
    assign shifted = buf_q >> shamt;
    assign sgn     = ~funct3_q[2];

    always_comb begin
        load_data = shifted;
        case (funct3_q[1:0])
            2'd0:    load_data = {{56{sgn & shifted[7]}},  shifted[7:0]};
            2'd1:    load_data = {{48{sgn & shifted[15]}}, shifted[15:0]};
            2'd2:    load_data = {{32{sgn & shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 64'd0;
        resp_err   = 1'b0;
        MemRead    = 1'b0;
        Mem_Addr   = 64'd0;
        Write_Data = 64'd0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            RD: begin
                MemRead  = 1'b1;
                Mem_Addr = addr_q;
            end
            WR: begin
                Mem_Addr   = addr_q;
                Write_Data = (funct3_q[1:0] == 2'd3) ? wdata_q : merged;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || store_q) ? 64'd0 : load_data;
            end
            default: ;
        endcase
    end

    // Gated by reset_n so that a reset arriving during WR suppresses the write.
    assign MemWrite = (state_q == WR) & reset_n;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int MEM_BYTES = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        MemRead, MemWrite;
    logic [63:0] Mem_Addr, Write_Data, Read_Data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];

    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, misal_cnt = 0;
    logic [63:0] last_raddr = '0, last_waddr = '0, last_wdata = '0;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .Mem_Addr(Mem_Addr),
        .Write_Data(Write_Data), .Read_Data(Read_Data)
    );

    always #5 clk = ~clk;

    always_comb begin
        Read_Data = '0;
        for (int i = 0; i < 8; i++)
            Read_Data[i*8 +: 8] = mem[int'((Mem_Addr + 64'(i)) % 64'(MEM_BYTES))];
    end

    always @(posedge clk) begin
        if (MemRead) begin
            rd_cnt++;
            last_raddr = Mem_Addr;
        end
        if (MemWrite) begin
            wr_cnt++;
            last_waddr = Mem_Addr;
            last_wdata = Write_Data;
            for (int i = 0; i < 8; i++)
                mem[int'((Mem_Addr + 64'(i)) % 64'(MEM_BYTES))] = Write_Data[i*8 +: 8];
        end
        if (MemRead && MemWrite) both_cnt++;
        if ((MemRead || MemWrite) && Mem_Addr[2:0] != 3'd0) misal_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-level memory semantics straight from the size/sign rules.
    task automatic model(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, output logic [63:0] rdata, output logic err,
                         output int lat, output int nrd, output int nwr);
        int          nb;
        int          off;
        int          base;
        logic [63:0] al;
        nb  = 1 << f3[1:0];
        off = int'(addr[2:0]);
        al  = addr & ~64'h7;
        err = ((off % nb) != 0) || (!st && f3 == 3'd7) || (st && f3[2]);
`ifdef LSU_BOUNDS_CHECK_EN
        if (al > 64'(MEM_BYTES - 8)) err = 1'b1;
        base = err ? 0 : int'(al);
`else
        base = int'(al % 64'(MEM_BYTES));
`endif
        rdata = '0;
        if (!err) begin
            if (st) begin
                for (int i = 0; i < nb; i++) ref_mem[base + off + i] = wd[i*8 +: 8];
            end else begin
                for (int i = 0; i < nb; i++) rdata[i*8 +: 8] = ref_mem[base + off + i];
                if (f3 < 3'd4 && nb < 8 && rdata[8*nb-1]) rdata = rdata | (~64'd0 << (8*nb));
            end
        end
        lat = err ? 1 : ((!st || f3[1:0] == 2'd3) ? 2 : 3);
        nrd = err ? 0 : ((st && f3[1:0] == 2'd3) ? 0 : 1);
        nwr = (!err && st) ? 1 : 0;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input int hold);
        logic [63:0] exp_rd;
        logic        exp_err;
        int          exp_lat, exp_nrd, exp_nwr, rd0, wr0, lat;
        logic        got;
        model(st, f3, addr, wd, exp_rd, exp_err, exp_lat, exp_nrd, exp_nwr);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        check("req_ready", req_ready, 1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1'b1;
        end
        check("resp_timeout", got, 1);
        if (!got) begin
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            return;
        end
        check("latency", lat, exp_lat);
        for (int c = 0; c < hold; c++) begin
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, exp_rd);
            check("hold_ready", req_ready, 0);
            @(negedge clk);
        end
        check("rdata", resp_rdata, exp_rd);
        check("err", resp_err, exp_err);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready", req_ready, 1);
        check("idle_valid", resp_valid, 0);
        check("n_reads", rd_cnt - rd0, exp_nrd);
        check("n_writes", wr_cnt - wr0, exp_nwr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_rdata"}, resp_rdata, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_MemRead"}, MemRead, 0);
        check({tag, "_MemWrite"}, MemWrite, 0);
        check({tag, "_Mem_Addr"}, Mem_Addr, 0);
        check({tag, "_Write_Data"}, Write_Data, 0);
    endtask

    // Issue a halfword store and pull reset during RD (in_wr=0) or WR (in_wr=1).
    task automatic reset_mid_store(input logic [63:0] addr, input logic in_wr);
        int wr0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = addr;
        req_wdata  = 64'hBEEF;
        resp_ready = 1'b1;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_in_rd", MemRead, 1);
        if (in_wr) begin
            @(negedge clk);
            check("mid_in_wr", MemWrite, 1);
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_no_write", wr_cnt - wr0, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]     = 8'd0;
            ref_mem[i] = 8'd0;
        end
        mem[0]  = 8'd4;  ref_mem[0]  = 8'd4;
        mem[8]  = 8'd11; ref_mem[8]  = 8'd11;
        mem[16] = 8'd21; ref_mem[16] = 8'd21;
        mem[24] = 8'd9;  ref_mem[24] = 8'd9;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        do_req(1'b0, 3'b011, 64'd8, 64'd0, 0);
        check("ld8_raddr", last_raddr, 64'd8);

        do_req(1'b1, 3'b000, 64'd17, 64'hFF, 0);
        check("sb17_wdata", last_wdata, 64'h0000_0000_0000_FF15);
        check("sb17_waddr", last_waddr, 64'd16);
        do_req(1'b0, 3'b011, 64'd16, 64'd0, 0);
        do_req(1'b0, 3'b000, 64'd17, 64'd0, 0);
        do_req(1'b0, 3'b100, 64'd17, 64'd0, 0);
        do_req(1'b0, 3'b001, 64'd16, 64'd0, 0);

        do_req(1'b0, 3'b010, 64'd6, 64'd0, 0);
        do_req(1'b1, 3'b111, 64'd8, 64'h1234, 0);
        do_req(1'b0, 3'b111, 64'd8, 64'd0, 0);

        do_req(1'b0, 3'b011, 64'd0, 64'd0, 3);

        reset_mid_store(64'd24, 1'b0);
        do_req(1'b0, 3'b011, 64'd24, 64'd0, 0);
        reset_mid_store(64'd32, 1'b1);
        do_req(1'b0, 3'b011, 64'd32, 64'd0, 0);

        do_req(1'b0, 3'b011, 64'd64, 64'd0, 0);
        do_req(1'b1, 3'b011, 64'd56, 64'hA5A5_0102_0304_0506, 0);
        do_req(1'b0, 3'b010, 64'd60, 64'd0, 1);

        for (int n = 0; n < 300; n++) begin
            logic [63:0] a;
            logic [63:0] w;
            if ($urandom_range(0, 7) == 0) a = {$urandom, $urandom};
            else                           a = 64'($urandom_range(0, MEM_BYTES - 1));
            w = {$urandom, $urandom};
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, w,
                   int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < MEM_BYTES; i++)
            check($sformatf("mem_%0d", i), mem[i], ref_mem[i]);
        check("both_rd_wr", both_cnt, 0);
        check("misaligned_mem_addr", misal_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory port. Accepts one load/store request at a time from the core, using RISC-V funct3 sizes. Drives the byte-addressed 64-bit data memory port (MemRead, MemWrite, Mem_Addr, Write_Data, Read_Data). Sub-doubleword stores are done as read-modify-write. Returns extended load data or an error flag through a valid/ready response.

Parameters:
MEM_BYTES, 64, data memory size in bytes (power of two, at least 8)

Ports:
clk  in  1  clock; memory writes on posedge
reset_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  unit idle, can accept a request
req_store  in  1  1=store, 0=load
req_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
req_addr  in  64  byte address
req_wdata  in  64  store data, right-aligned
resp_valid  out  1  response valid
resp_ready  in  1  response accepted
resp_rdata  out  64  load result, extended
resp_err  out  1  misaligned, illegal funct3 or out-of-bounds access
MemRead  out  1  memory read enable
MemWrite  out  1  memory write enable
Mem_Addr  out  64  memory address, always 8-byte aligned
Write_Data  out  64  memory write data
Read_Data  in  64  memory read data (combinational, same cycle)

Behaviour:
- One clock domain (clk); reset is synchronous and active-low (reset_n).
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, MemRead=0, MemWrite=0, Mem_Addr=0, Write_Data=0.
- Memory-side outputs decode only from registered state and registers. Exception: MemWrite = (state==WR) & reset_n.
- Size sz = funct3[1:0]; offset off = addr[2:0]; aligned address = addr with bits [2:0] cleared.
- Latched error conditions:
  - off not a multiple of 2^sz.
  - Load with funct3=111.
  - Store with funct3[2]=1.
- States:
  - IDLE: req_ready=1. On req_valid, latch the request.
    - Error -> RESP with resp_err=1.
    - Load -> RD.
    - Doubleword store -> WR.
    - Other store -> RD.
  - RD: MemRead=1, Mem_Addr=aligned address. Capture Read_Data into a buffer at the posedge. Load -> RESP; store -> WR.
  - WR: MemWrite=1, Mem_Addr=aligned address. Write_Data = req_wdata for a doubleword, otherwise buffer with lane bytes [off .. off+2^sz-1] replaced by the low 2^sz bytes of req_wdata. -> RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err are stable until resp_ready; then -> IDLE.
- Load result: bytes taken from the buffer starting at lane off. Sign-extended for b/h/w/d; zero-extended for bu/hu/wu. resp_rdata=0 on error.
- Latency from the accept edge T, with resp_ready held high:
  - Error: resp_valid at T+1.
  - Load or doubleword store: T+2.
  - Sub-doubleword store: T+3.
- Back-to-back: a new request can be accepted the cycle after the RESP handshake.
- MemRead and MemWrite are never both high. Each is high exactly one cycle per access; no memory access on an error.
- Reset mid-operation: state returns to IDLE and the request is dropped. reset_n low during WR suppresses the write, so the memory is unchanged.

Optional Feature:
LSU_BOUNDS_CHECK_EN
- Defined: aligned address + 8 > MEM_BYTES raises resp_err=1 with no memory access, same timing as a misalignment error.
- Undefined: Mem_Addr is the aligned address truncated modulo MEM_BYTES (wrap-around); no bounds error.

Test Plan:
- Memory preloaded with byte[8]=11, resp_ready=1; ld addr 8 -> MemRead high one cycle at T+1, resp_valid at T+2, resp_rdata=64'd11, resp_err=0.
- sb 0xFF at addr 17 (byte[16]=21) -> sequence RD, WR, RESP at T+3; MemWrite high exactly one cycle with Write_Data=64'h000000000000FF15. Then ld 16 -> 64'h000000000000FF15.
- After the previous store: lb addr 17 -> 64'hFFFFFFFFFFFFFFFF; lbu addr 17 -> 64'h00000000000000FF; lh addr 16 -> 64'hFFFFFFFFFFFFFF15.
- lw addr 6; sd with funct3=111 -> resp_err=1, resp_valid at T+1, resp_rdata=0, MemRead/MemWrite never asserted.
- ld addr 0 (byte[0]=4) with resp_ready low 3 cycles -> resp_valid, resp_rdata=4 and req_ready=0 held; IDLE one cycle after resp_ready rises.
- sh 0xBEEF at addr 24; reset_n low during the RD cycle -> no MemWrite, outputs at reset values, ld 24 returns 9. With LSU_BOUNDS_CHECK_EN, ld addr 64 -> resp_err=1 at T+1.
